// File: rtl/bist_controller.sv
// ---------------------------------------------------------------------------
// bist_controller
//
// Sequences one built-in self-test session over the circuit under test.
// A rising edge on start seeds the LFSR pattern generator, clears the MISR
// and switches the CUT input mux to test mode. The controller then applies
// N_PATTERNS patterns, flushes PIPE_LAT cycles of CUT pipeline into the
// MISR, compares the resulting signature against GOLDEN_SIG and reports
// the verdict until the next session request or reset.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   start      in   1      session request (level; rising edge acts)
//   misr_sig   in   SIG_W  current MISR signature (sampled in COMPARE only)
//   lfsr_load  out  1      load LFSR seed
//   lfsr_en    out  1      advance LFSR one pattern
//   misr_clr   out  1      clear MISR to its init value
//   misr_en    out  1      MISR captures CUT output this cycle
//   test_mode  out  1      CUT-input mux selects the LFSR
//   running    out  1      session in progress
//   bist_end   out  1      session complete; held until next start or rst
//   out        out  1      1 = signature matched; valid while bist_end=1
// ---------------------------------------------------------------------------
module bist_controller #(
    parameter int unsigned      N_PATTERNS = 1000,
    parameter int unsigned      PIPE_LAT   = 2,
    parameter int unsigned      CNT_W      = 12,
    parameter int unsigned      SIG_W      = 16,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             lfsr_load,
    output logic             lfsr_en,
    output logic             misr_clr,
    output logic             misr_en,
    output logic             test_mode,
    output logic             running,
    output logic             bist_end,
    output logic             out
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        FLUSH,
        COMPARE,
        DONE
    } state_t;

    // Terminal counts. LAST_FLUSH is never reached when PIPE_LAT == 0
    // because RUN goes straight to COMPARE in that configuration.
    localparam logic [CNT_W-1:0] LAST_PAT   = CNT_W'(N_PATTERNS - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(PIPE_LAT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             start_q;
    logic             out_r;
    logic             out_r_nxt;
    logic             start_rise;
    logic             fill_ok;

    assign start_rise = start & ~start_q;

    // The MISR only starts capturing once the first pattern has travelled
    // through the CUT pipeline; with no pipeline it captures immediately.
    generate
        if (PIPE_LAT == 0) begin : g_nofill
            assign fill_ok = 1'b1;
        end else begin : g_fill
            assign fill_ok = (cnt >= CNT_W'(PIPE_LAT));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
            out_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            start_q <= start;
            out_r   <= out_r_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_r_nxt = out_r;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        misr_clr  = 1'b0;
        misr_en   = 1'b0;
        test_mode = 1'b0;
        running   = 1'b0;
        bist_end  = 1'b0;
        out       = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start_rise) begin
                    state_nxt = INIT;
                end
            end

            INIT: begin
                lfsr_load = 1'b1;
                misr_clr  = 1'b1;
                test_mode = 1'b1;
                running   = 1'b1;
                out_r_nxt = 1'b0;
                cnt_nxt   = '0;
                state_nxt = RUN;
            end

            RUN: begin
                lfsr_en   = 1'b1;
                test_mode = 1'b1;
                running   = 1'b1;
                misr_en   = fill_ok;
                if (cnt == LAST_PAT) begin
                    cnt_nxt   = '0;
                    state_nxt = (PIPE_LAT > 0) ? FLUSH : COMPARE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            FLUSH: begin
                misr_en   = 1'b1;
                test_mode = 1'b1;
                running   = 1'b1;
                if (cnt == LAST_FLUSH) begin
                    cnt_nxt   = '0;
                    state_nxt = COMPARE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            COMPARE: begin
                test_mode = 1'b1;
                running   = 1'b1;
                out_r_nxt = (misr_sig == GOLDEN_SIG);
                cnt_nxt   = '0;
                state_nxt = DONE;
            end

            DONE: begin
                bist_end = 1'b1;
                out      = out_r;
                cnt_nxt  = '0;
                if (start_rise) begin
                    state_nxt = INIT;
                end
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
